// File: rtl/ram_bus_master.sv
// Burst initiator for the 8-bit RAM port: valid/ready requests become single-cycle RAM strobes
// with auto-incrementing, wrapping addresses. Optional write-verify readback under WRITE_VERIFY_EN.
module ram_bus_master #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_last,
  output logic              done,
  output logic              err,
  input  logic              err_clr,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_CAP,
    RD_HOLD,
    WR_WAIT,
    WR_ISSUE
`ifdef WRITE_VERIFY_EN
    ,
    VF_ISSUE,
    VF_CHECK
`endif
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  beat_cnt;
  logic              last;
  logic              accept;
  logic              beat_done;
  logic              strobe_next;

  assign last     = (beat_cnt == len_q);
  assign accept   = (state == IDLE) && req_valid && req_ready;
  assign ram_addr = cur_addr;

  // beat_done marks the cycle in which a beat retires and the address may advance
  always_comb begin
    next_state = state;
    beat_done  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) next_state = req_we ? WR_WAIT : RD_ISSUE;
      end
      RD_ISSUE: next_state = RD_CAP;
      RD_CAP:   next_state = RD_HOLD;
      RD_HOLD: begin
        if (rdata_ready) begin
          beat_done  = 1'b1;
          next_state = last ? IDLE : RD_ISSUE;
        end
      end
      WR_WAIT: begin
        if (wdata_valid) next_state = WR_ISSUE;
      end
`ifdef WRITE_VERIFY_EN
      WR_ISSUE: next_state = VF_ISSUE;
      VF_ISSUE: next_state = VF_CHECK;
      VF_CHECK: begin
        beat_done  = 1'b1;
        next_state = last ? IDLE : WR_WAIT;
      end
`else
      WR_ISSUE: begin
        beat_done  = 1'b1;
        next_state = last ? IDLE : WR_WAIT;
      end
`endif
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    strobe_next = 1'b0;
    case (next_state)
      RD_ISSUE: strobe_next = 1'b1;
      WR_ISSUE: strobe_next = 1'b1;
`ifdef WRITE_VERIFY_EN
      VF_ISSUE: strobe_next = 1'b1;
`endif
      default:  strobe_next = 1'b0;
    endcase
  end

  // Handshake and strobe outputs are registered from next_state so they line up with the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      req_ready   <= 1'b0;
      wdata_ready <= 1'b0;
      rdata_valid <= 1'b0;
      rdata       <= '0;
      rdata_last  <= 1'b0;
      done        <= 1'b0;
      ram_ce      <= 1'b0;
      ram_we      <= 1'b0;
      ram_din     <= '0;
      cur_addr    <= '0;
      len_q       <= '0;
      beat_cnt    <= '0;
    end else begin
      state       <= next_state;
      req_ready   <= (next_state == IDLE);
      wdata_ready <= (next_state == WR_WAIT);
      rdata_valid <= (next_state == RD_HOLD);
      ram_ce      <= strobe_next;
      ram_we      <= (next_state == WR_ISSUE);
      done        <= (next_state == IDLE) && (state != IDLE);

      if (accept) begin
        cur_addr <= req_addr;
        len_q    <= req_len;
        beat_cnt <= '0;
      end else if (beat_done && !last) begin
        cur_addr <= cur_addr + ADDR_W'(1);
        beat_cnt <= beat_cnt + LEN_W'(1);
      end

      if (state == RD_CAP) begin
        rdata      <= ram_dout;
        rdata_last <= last;
      end else if (state == RD_HOLD && rdata_ready) begin
        rdata_last <= 1'b0;
      end

      if (state == WR_WAIT && wdata_valid) ram_din <= wdata;
    end
  end

`ifdef WRITE_VERIFY_EN
  // Clear takes priority so software never loses a clear to a concurrent mismatch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (err_clr) begin
      err <= 1'b0;
    end else if (state == VF_CHECK && ram_dout != ram_din) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_ram_bus_master.sv
// Randomized self-checking bench for ram_bus_master with a behavioural RAM and a flat memory
// reference model; define WRITE_VERIFY_EN to also exercise the verify path.
module tb_ram_bus_master;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [7:0] req_addr;
  logic [3:0] req_len;
  logic       wdata_valid;
  logic       wdata_ready;
  logic [7:0] wdata;
  logic       rdata_valid;
  logic       rdata_ready;
  logic [7:0] rdata;
  logic       rdata_last;
  logic       done;
  logic       err;
  logic       err_clr;
  logic       ram_ce;
  logic       ram_we;
  logic [7:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;

`ifdef WRITE_VERIFY_EN
  localparam int WR_TAIL = 3;
`else
  localparam int WR_TAIL = 1;
`endif

  logic [7:0] ram_mem[256];
  bit         mem_valid[256];
  logic [7:0] model_mem[256];
  logic [7:0] wr_data_q[$];
  bit         stuck0;

  int checks_total;
  int checks_passed;
  int ce_cnt;
  int we_cnt;
  int done_cnt;
  int done_exp;

  ram_bus_master #(.ADDR_W(8), .DATA_W(8), .LEN_W(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .rdata_last(rdata_last), .done(done), .err(err), .err_clr(err_clr),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] initPattern(input logic [7:0] a);
    return a ^ 8'h5A;
  endfunction

  // Registered-output RAM; unwritten locations read back a fixed address pattern
  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_we) begin
        ram_mem[ram_addr]   <= stuck0 ? {ram_din[7:1], 1'b0} : ram_din;
        mem_valid[ram_addr] <= 1'b1;
      end else begin
        ram_dout <= mem_valid[ram_addr] ? ram_mem[ram_addr] : initPattern(ram_addr);
      end
    end
  end

  always @(posedge clk) begin
    if (ram_ce)           ce_cnt   <= ce_cnt + 1;
    if (ram_ce && ram_we) we_cnt   <= we_cnt + 1;
    if (done)             done_cnt <= done_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    if (obs === exp) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic startReq(input bit we, input logic [7:0] addr, input int len, output int waited);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_len   = len[3:0];
    waited    = 0;
    while (!req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) checkOutput("req_timeout", 0, 1);
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = $urandom_range(0, 1);
    req_addr  = 8'($urandom);
    req_len   = 4'($urandom);
  endtask

  // Writes len+1 beats; abortAt >= 0 asserts reset while that beat's strobe is live
  task automatic writeBurst(input logic [7:0] addr, input int len, input int gapMax, input int abortAt);
    int         waited;
    int         n;
    int         we0;
    logic [7:0] d;
    logic [7:0] a;
    we0 = we_cnt;
    startReq(1'b1, addr, len, waited);
    for (int i = 0; i <= len; i++) begin
      repeat ($urandom_range(0, gapMax)) @(negedge clk);
      d = (wr_data_q.size() > 0) ? wr_data_q.pop_front() : 8'($urandom);
      a = addr + 8'(i);
      wdata_valid = 1'b1;
      wdata       = d;
      n = 0;
      while (!wdata_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (n >= 20) checkOutput("wdata_timeout", 0, 1);
      @(negedge clk);
      wdata_valid = 1'b0;
      wdata       = 8'($urandom);
      if (i == abortAt) begin
        checkOutput("abort_strobe_live", {ram_ce, ram_we}, 2'b11);
        rst = 1'b1;
        #1;
        checkOutput("abort_outputs_zero",
                    {req_ready, wdata_ready, rdata_valid, done, ram_ce, ram_we}, 6'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_ready_back", req_ready, 1'b1);
        return;
      end
      model_mem[a] = stuck0 ? {d[7:1], 1'b0} : d;
    end
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wr_done_latency", n, WR_TAIL);
    checkOutput("wr_strobe_count", we_cnt - we0, len + 1);
    done_exp++;
  endtask

  // Reads len+1 beats; stall<0 picks random back-pressure; holdNext presents the next request early
  task automatic readBurst(input logic [7:0] addr, input int len, input int stall,
                           input bit holdNext, input logic [7:0] nextAddr, input int nextLen);
    int         waited;
    int         lat;
    int         st;
    int         ce0;
    bit         hold_ok;
    logic [7:0] a;
    ce0 = ce_cnt;
    startReq(1'b0, addr, len, waited);
    if (holdNext) begin
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = nextAddr;
      req_len   = nextLen[3:0];
    end
    lat = 1;
    while (!rdata_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("rd_first_latency", lat, 3);
    for (int i = 0; i <= len; i++) begin
      a = addr + 8'(i);
      lat = 0;
      while (!rdata_valid && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      if (lat >= 20) checkOutput("rdata_timeout", 0, 1);
      checkOutput("rd_data", rdata, model_mem[a]);
      checkOutput("rd_last", rdata_last, (i == len));
      st = (stall < 0) ? $urandom_range(0, 2) : stall;
      hold_ok = 1'b1;
      repeat (st) begin
        @(negedge clk);
        if (rdata !== model_mem[a] || rdata_valid !== 1'b1 || req_ready !== 1'b0) hold_ok = 1'b0;
      end
      checkOutput("rd_hold_stable", hold_ok, 1'b1);
      rdata_ready = 1'b1;
      @(negedge clk);
      rdata_ready = 1'b0;
    end
    checkOutput("rd_done_ready", {done, req_ready}, 2'b11);
    checkOutput("rd_strobe_count", ce_cnt - ce0, len + 1);
    done_exp++;
  endtask

  task automatic applyStimulus(input int nBursts);
    logic [7:0] addr;
    int         len;
    for (int k = 0; k < nBursts; k++) begin
      addr = 8'($urandom);
      len  = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) writeBurst(addr, len, 2, -1);
      else                           readBurst(addr, len, -1, 1'b0, 8'h00, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got no finish expected finish");
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    int waited;
    checks_total = 0;
    checks_passed = 0;
    ce_cnt = 0;
    we_cnt = 0;
    done_cnt = 0;
    done_exp = 0;
    stuck0 = 1'b0;
    for (int i = 0; i < 256; i++) model_mem[i] = initPattern(8'(i));
    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_len = '0;
    wdata_valid = 1'b0;
    wdata = '0;
    rdata_ready = 1'b0;
    err_clr = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("reset_outputs",
                {req_ready, wdata_ready, rdata_valid, rdata, rdata_last, done, err,
                 ram_ce, ram_we, ram_addr, ram_din}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", req_ready, 1'b1);

    $display("[TB] single-beat write/read");
    wr_data_q = '{8'hAB};
    writeBurst(8'h01, 0, 0, -1);
    readBurst(8'h01, 0, 0, 1'b0, 8'h00, 0);

    $display("[TB] wrapping burst");
    wr_data_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    writeBurst(8'hFE, 3, 0, -1);
    readBurst(8'hFE, 3, 1, 1'b0, 8'h00, 0);

    $display("[TB] read back-pressure");
    readBurst(8'h2A, 1, 5, 1'b0, 8'h00, 0);

    $display("[TB] request held while busy, accepted in done cycle");
    readBurst(8'h10, 1, 2, 1'b1, 8'hFE, 1);
    startReq(1'b0, 8'hFE, 1, waited);
    checkOutput("b2b_accept_wait", waited, 0);
    // startReq already consumed the accept edge; finish the second burst by hand
    for (int i = 0; i <= 1; i++) begin
      int n = 0;
      while (!rdata_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      checkOutput("b2b_rd_data", rdata, model_mem[8'hFE + 8'(i)]);
      rdata_ready = 1'b1;
      @(negedge clk);
      rdata_ready = 1'b0;
    end
    checkOutput("b2b_done", done, 1'b1);
    done_exp++;

    $display("[TB] reset during write burst");
    writeBurst(8'h80, 7, 1, 2);
    readBurst(8'h80, 7, 0, 1'b0, 8'h00, 0);

`ifdef WRITE_VERIFY_EN
    $display("[TB] write-verify with stuck bit");
    stuck0 = 1'b1;
    wr_data_q = '{8'h3D};
    writeBurst(8'h50, 0, 0, -1);
    stuck0 = 1'b0;
    checkOutput("verify_err_set", err, 1'b1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
    checkOutput("verify_err_clr", err, 1'b0);
`endif

    $display("[TB] randomized bursts");
    applyStimulus(24);

    repeat (3) @(negedge clk);
    checkOutput("err_idle", err, 1'b0);
    checkOutput("done_pulse_total", done_cnt, done_exp);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
